// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: byte stream -> big-endian words on the RAM write port.
// Define IMEM_LOADER_CHECKSUM_EN to add the trailing checksum byte and the err report.
module imem_loader #(
   parameter int AW = 6
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   output logic          we,
   output logic [AW-1:0] wa,
   output logic [31:0]   wd,
   output logic          busy,
   output logic          cpu_hold,
   output logic          done,
   output logic          err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {S_IDLE, S_COUNT, S_DATA, S_CHECK, S_DONE} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_COUNT, S_DATA, S_DONE} state_t;
`endif

   localparam logic [AW-1:0] ONE = AW'(1);

   state_t        state_q, state_d;
   logic [1:0]    byte_cnt_q, byte_cnt_d;
   logic [AW-1:0] word_cnt_q, word_cnt_d;
   logic [AW-1:0] last_q, last_d;       // index of the final word (N-1, wraps so count 0 gives 2^AW words)
   logic [23:0]   shift_q, shift_d;
   logic          we_q, we_d;
   logic [AW-1:0] wa_q, wa_d;
   logic [31:0]   wd_q, wd_d;
   logic          xfer;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]    csum_q, csum_d;
   logic          err_q, err_d;
`endif

   assign in_ready = (state_q == S_COUNT) || (state_q == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                  || (state_q == S_CHECK)
`endif
                  ;
   assign xfer     = in_valid && in_ready;
   assign busy     = in_ready;
   assign cpu_hold = in_ready;
   assign done     = (state_q == S_DONE);
   assign we       = we_q;
   assign wa       = wa_q;
   assign wd       = wd_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
   assign err      = err_q;
`else
   assign err      = 1'b0;
`endif

   // NOTE: every variable gets its hold value before the case, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      word_cnt_d = word_cnt_q;
      last_d     = last_q;
      shift_d    = shift_q;
      we_d       = 1'b0;
      wa_d       = wa_q;
      wd_d       = wd_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d     = csum_q;
      err_d      = err_q;
`endif
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d    = S_COUNT;
               byte_cnt_d = 2'd0;
               word_cnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d     = 8'd0;
               err_d      = 1'b0;
`endif
            end
         end
         S_COUNT: begin
            if (xfer) begin
               last_d  = AW'(in_data) - ONE;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (xfer) begin
               byte_cnt_d = byte_cnt_q + 2'd1;
               shift_d    = {shift_q[15:0], in_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d     = csum_q + in_data;
`endif
               if (byte_cnt_q == 2'd3) begin
                  we_d       = 1'b1;
                  wa_d       = word_cnt_q;
                  wd_d       = {shift_q, in_data};
                  word_cnt_d = word_cnt_q + ONE;
                  if (word_cnt_q == last_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     state_d = S_CHECK;
`else
                     state_d = S_DONE;
`endif
                  end
               end
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHECK: begin
            if (xfer) begin
               err_d   = (in_data != csum_q);
               state_d = S_DONE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         byte_cnt_q <= 2'd0;
         word_cnt_q <= '0;
         last_q     <= '0;
         shift_q    <= 24'd0;
         we_q       <= 1'b0;
         wa_q       <= '0;
         wd_q       <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q     <= 8'd0;
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         word_cnt_q <= word_cnt_d;
         last_q     <= last_d;
         shift_q    <= shift_d;
         we_q       <= we_d;
         wa_q       <= wa_d;
         wd_q       <= wd_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q     <= csum_d;
         err_q      <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame table, write scoreboard and corner-case sequences.
module tb_imem_loader;

   localparam int AW = 6;

   typedef struct {
      logic [7:0] count;
      bit         fixed;       // use the fixed 8-byte pattern instead of random data
      bit         bad;         // send a wrong checksum byte
      bit         stall;       // random in_valid gaps
      bit         pulse;       // pulse start during the gaps
      int         abort;       // reset after this many data bytes (0 = none)
      int         exp_writes;
      bit         exp_err;
   } frame_t;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic [7:0]    in_data = 8'd0;
   logic          in_ready, we, busy, cpu_hold, done, err;
   logic [AW-1:0] wa;
   logic [31:0]   wd;

   int checks = 0;
   int errors = 0;
   int we_count = 0;
   int cyc = 0;
   logic hs_prev = 1'b0;
   logic [AW+31:0] exp_q[$];
   logic [7:0] fixed_bytes [8];
   frame_t vec [7];

   imem_loader #(.AW(AW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .we(we), .wa(wa), .wd(wd), .busy(busy), .cpu_hold(cpu_hold),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      hs_prev <= in_valid && in_ready;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Write monitor: every we pulse must follow an accepted byte and match the scoreboard head.
   always @(negedge clk) begin
      logic [AW+31:0] e;
      if (we) begin
         we_count++;
         check("we_follows_byte", 64'(hs_prev), 64'd1);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_we: got wa=%0d wd=%h expected no write", wa, wd);
         end else begin
            e = exp_q.pop_front();
            check("write_addr_data", 64'({wa, wd}), 64'(e));
         end
      end
   end

   // Called at a negedge; returns at the negedge after the byte is accepted.
   task automatic send_byte(input logic [7:0] b, input bit stall, input bit pulse, output int c);
      bit ok = 1'b0;
      if (stall) begin
         repeat ($urandom_range(0, 2)) begin
            in_valid = 1'b0;
            start    = pulse;
            @(negedge clk);
            start    = 1'b0;
         end
      end
      in_valid = 1'b1;
      in_data  = b;
      for (int k = 0; k < 50 && !ok; k++) begin
         if (in_ready) begin
            @(posedge clk);
            @(negedge clk);
            ok = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      in_valid = 1'b0;
      c = cyc;
      if (!ok) check("byte_accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", 64'(busy), 64'd1);
      check("hold_after_start", 64'(cpu_hold), 64'd1);
      check("done_clear_after_start", 64'(done), 64'd0);
      check("err_clear_after_start", 64'(err), 64'd0);
   endtask

   task automatic run_frame(input frame_t f, input bit skip_start);
      int n, c0, c, w0, sent;
      logic [7:0] bytes [4];
      logic [7:0] csum;
      logic [31:0] w;
      bit aborted, exp_err;
      n = (f.count[AW-1:0] == 0) ? (1 << AW) : int'(f.count[AW-1:0]);
      w0 = we_count;
      csum = 8'd0;
      sent = 0;
      aborted = 1'b0;
      c = 0;
      if (!skip_start) do_start();
      send_byte(f.count, f.stall, f.pulse, c0);
      for (int i = 0; i < n && !aborted; i++) begin
         for (int j = 0; j < 4; j++) begin
            bytes[j] = f.fixed ? fixed_bytes[(i * 4 + j) % 8] : 8'($urandom);
            w = {w[23:0], bytes[j]};
         end
         if (f.abort == 0 || (i * 4 + 4) <= f.abort) exp_q.push_back({AW'(i), w});
         for (int j = 0; j < 4 && !aborted; j++) begin
            send_byte(bytes[j], f.stall, f.pulse, c);
            csum = csum + bytes[j];
            sent++;
            if (f.abort != 0 && sent == f.abort) aborted = 1'b1;
         end
      end
      if (aborted) begin
         reset_n = 1'b0;
         @(negedge clk);
         check("rst_in_ready", 64'(in_ready), 64'd0);
         check("rst_we", 64'(we), 64'd0);
         check("rst_wa_wd", 64'({wa, wd}), 64'd0);
         check("rst_busy_hold", 64'({busy, cpu_hold}), 64'd0);
         check("rst_done_err", 64'({done, err}), 64'd0);
         reset_n = 1'b1;
         @(negedge clk);
         check("abort_write_count", 64'(we_count - w0), 64'(f.exp_writes));
         check("abort_queue_empty", 64'(exp_q.size()), 64'd0);
         return;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(f.bad ? (csum == 8'd0 ? 8'd1 : 8'd0) : csum, f.stall, f.pulse, c);
      exp_err = f.exp_err;
`else
      exp_err = 1'b0;
`endif
      check("done_at_end", 64'(done), 64'd1);
      check("busy_at_end", 64'({busy, cpu_hold}), 64'd0);
      check("in_ready_in_done", 64'(in_ready), 64'd0);
      check("err_at_end", 64'(err), 64'(exp_err));
      if (!f.stall) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
         check("frame_latency", 64'(c - c0 + 1), 64'(4 * n + 2));
`else
         check("frame_latency", 64'(c - c0 + 1), 64'(4 * n + 1));
`endif
      end
      @(negedge clk);
      check("done_held", 64'(done), 64'd1);
      check("write_count", 64'(we_count - w0), 64'(f.exp_writes));
      check("queue_empty", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      frame_t hs;
      fixed_bytes[0] = 8'h8C; fixed_bytes[1] = 8'h01; fixed_bytes[2] = 8'h00; fixed_bytes[3] = 8'h04;
      fixed_bytes[4] = 8'h20; fixed_bytes[5] = 8'h42; fixed_bytes[6] = 8'hFF; fixed_bytes[7] = 8'hFF;
      //                count   fixed bad stall pulse abort writes err
      vec[0] = '{8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 0,  2, 1'b0};
      vec[1] = '{8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 0,  2, 1'b1};
      vec[2] = '{8'h40, 1'b0, 1'b0, 1'b0, 1'b0, 0, 64, 1'b0};
      vec[3] = '{8'hC1, 1'b0, 1'b0, 1'b0, 1'b0, 0,  1, 1'b0};
      vec[4] = '{8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 0,  3, 1'b0};
      vec[5] = '{8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 6,  1, 1'b0};
      vec[6] = '{8'h02, 1'b1, 1'b0, 1'b1, 1'b1, 0,  2, 1'b0};

      repeat (3) @(negedge clk);
      check("reset_in_ready", 64'(in_ready), 64'd0);
      check("reset_we", 64'(we), 64'd0);
      check("reset_wa_wd", 64'({wa, wd}), 64'd0);
      check("reset_busy_hold", 64'({busy, cpu_hold}), 64'd0);
      check("reset_done_err", 64'({done, err}), 64'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check("idle_no_ready", 64'(in_ready), 64'd0);

      for (int i = 0; i < 7; i++) run_frame(vec[i], 1'b0);

      // start coinciding with a byte offer in DONE: the byte must not be taken.
      check("done_before_combo", 64'(done), 64'd1);
      check("ready_low_in_done", 64'(in_ready), 64'd0);
      start    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h55;
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
      check("combo_busy", 64'(busy), 64'd1);
      check("combo_done_clear", 64'(done), 64'd0);
      hs = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0};
      run_frame(hs, 1'b1);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish by 200000");
      $fatal(1, "timeout");
   end

endmodule
